// File: rtl/cordic_freq_disc_pkg.sv
// cordic_freq_disc_pkg: shared state type and phase constants for the CORDIC frequency discriminator
package cordic_fd_pkg;
  typedef enum logic {S_EMPTY, S_RUN} state_t;
  function automatic logic signed [31:0] pi_c(input int xy_wdt);
    return 32'sd1 <<< xy_wdt;
  endfunction
  function automatic logic signed [31:0] two_pi_c(input int xy_wdt);
    return 32'sd2 <<< xy_wdt;
  endfunction
endpackage

// File: rtl/cordic_freq_disc_if.sv
// cordic_freq_disc_if: CORDIC result capture inputs and discriminator outputs
interface cordic_freq_disc_if #(parameter int XY_WDT = 16);
  logic st_in, rdy_in;
  logic [XY_WDT-1:0] mag, thr;
  logic signed [XY_WDT+1:0] ph, dph, freq;
  logic dph_vld, freq_vld, sq;
  modport master(output st_in, rdy_in, mag, ph, thr, input dph, dph_vld, freq, freq_vld, sq);
  modport slave(input st_in, rdy_in, mag, ph, thr, output dph, dph_vld, freq, freq_vld, sq);
endinterface

// File: rtl/cordic_ph_wrap.sv
// cordic_ph_wrap: phase difference ph - ph_prev wrapped into (-pi, pi]
module cordic_ph_wrap import cordic_fd_pkg::*; #(
  parameter int XY_WDT = 16
) (
  input  logic signed [XY_WDT+1:0] ph,
  input  logic signed [XY_WDT+1:0] ph_prev,
  output logic signed [XY_WDT+1:0] dph
);
  localparam int PW = XY_WDT + 2;
  localparam logic signed [PW:0] PI = (PW+1)'(pi_c(XY_WDT));
  localparam logic signed [PW:0] TWO_PI = (PW+1)'(two_pi_c(XY_WDT));
  logic signed [PW:0] raw, wrp;
  // one extra bit holds the raw step; a single +/-2pi correction brings it back into range
  always_comb begin
    raw = $signed({ph[PW-1], ph}) - $signed({ph_prev[PW-1], ph_prev});
    wrp = raw > PI ? raw - TWO_PI : raw <= -PI ? raw + TWO_PI : raw;
    dph = wrp[PW-1:0];
  end
endmodule

// File: rtl/cordic_freq_disc.sv
// cordic_freq_disc: FM discriminator with block average over CORDIC phase; squelch enabled by CORDIC_FD_SQUELCH_EN
module cordic_freq_disc import cordic_fd_pkg::*; #(
  parameter int XY_WDT = 16,
  parameter int AVG_LOG2 = 3
) (
  input logic clk,
  input logic reset,
  input logic sclr,
  input logic en,
  cordic_freq_disc_if.slave bus
);
  localparam int PW = XY_WDT + 2;
  localparam int AW = PW + AVG_LOG2;
`ifdef CORDIC_FD_SQUELCH_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic armed_q, armed_d, rdy_dly_q, rdy_dly_d;
  logic dph_vld_q, dph_vld_d, freq_vld_q, freq_vld_d, sq_q, sq_d;
  logic signed [PW-1:0] ph_prev_q, ph_prev_d, dph_q, dph_d, freq_q, freq_d, dph_w;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic new_res, sq_hit;
  cordic_ph_wrap #(.XY_WDT(XY_WDT)) u_wrap (.ph(bus.ph), .ph_prev(ph_prev_q), .dph(dph_w));
  // a rising rdy only counts when a start was seen since the last result
  always_comb begin
    new_res = bus.rdy_in & ~rdy_dly_q & armed_q;
    sq_hit = SQ_EN & new_res & (bus.mag < bus.thr);
    sum = acc_q + AW'(dph_w);
    rdy_dly_d = bus.rdy_in;
    armed_d = bus.st_in | (armed_q & ~new_res);
    state_d = state_q;
    ph_prev_d = ph_prev_q;
    dph_d = dph_q;
    freq_d = freq_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    dph_vld_d = 1'b0;
    freq_vld_d = 1'b0;
    sq_d = sq_hit;
    if (sq_hit) begin
      state_d = S_EMPTY;
      acc_d = '0;
      cnt_d = '0;
    end else if (new_res) begin
      ph_prev_d = bus.ph;
      state_d = S_RUN;
      if (state_q == S_RUN) begin
        dph_d = dph_w;
        dph_vld_d = 1'b1;
        freq_vld_d = &cnt_q;
        freq_d = freq_vld_d ? PW'(sum >>> AVG_LOG2) : freq_q;
        acc_d = freq_vld_d ? '0 : sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (sclr) begin
      state_d = S_EMPTY;
      armed_d = 1'b0;
      rdy_dly_d = 1'b1;
      ph_prev_d = '0;
      dph_d = '0;
      freq_d = '0;
      acc_d = '0;
      cnt_d = '0;
      dph_vld_d = 1'b0;
      freq_vld_d = 1'b0;
      sq_d = 1'b0;
    end
  end
  // all state advances only on enabled cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_EMPTY;
      armed_q <= 1'b0;
      rdy_dly_q <= 1'b1;
      ph_prev_q <= '0;
      dph_q <= '0;
      freq_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      dph_vld_q <= 1'b0;
      freq_vld_q <= 1'b0;
      sq_q <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      armed_q <= armed_d;
      rdy_dly_q <= rdy_dly_d;
      ph_prev_q <= ph_prev_d;
      dph_q <= dph_d;
      freq_q <= freq_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dph_vld_q <= dph_vld_d;
      freq_vld_q <= freq_vld_d;
      sq_q <= sq_d;
    end
  assign bus.dph = dph_q;
  assign bus.dph_vld = dph_vld_q;
  assign bus.freq = freq_q;
  assign bus.freq_vld = freq_vld_q;
  assign bus.sq = sq_q;
endmodule

// File: tb/tb_cordic_freq_disc.sv
// tb_cordic_freq_disc: randomized scoreboard bench for cordic_freq_disc against a phase-difference model
module tb_cordic_freq_disc;
  localparam int XY = 16;
  localparam int AL = 2;
  localparam int NBLK = 1 << AL;
  localparam int PI = 1 << XY;
  localparam int THR = 100;
`ifdef CORDIC_FD_SQUELCH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, sclr = 1'b0, en = 1'b1;
  cordic_freq_disc_if #(.XY_WDT(XY)) bus();
  cordic_freq_disc #(.XY_WDT(XY), .AVG_LOG2(AL)) dut (.clk(clk), .reset(reset), .sclr(sclr), .en(en), .bus(bus));
  always #5 clk = ~clk;

  int pass_n = 0, tot_n = 0;
  function automatic void chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  typedef struct {bit sq; int d; bit fv; int f;} exp_t;
  exp_t exp_q[$];
  bit m_arm = 0, m_have = 0;
  int m_prev = 0;
  int m_blk[$];

  function automatic void model_result(input int mg, input int p);
    exp_t e;
    e = '{0, 0, 0, 0};
    if (SQ && mg < THR) begin
      e.sq = 1;
      exp_q.push_back(e);
      m_have = 0;
      m_blk.delete();
      return;
    end
    if (!m_have) begin
      m_have = 1;
      m_prev = p;
      return;
    end
    e.d = p - m_prev;
    if (e.d > PI) e.d -= 2 * PI;
    else if (e.d <= -PI) e.d += 2 * PI;
    m_prev = p;
    m_blk.push_back(e.d);
    if (m_blk.size() == NBLK) begin
      int s;
      s = 0;
      foreach (m_blk[i]) s += m_blk[i];
      e.fv = 1;
      e.f = s >= 0 ? s / NBLK : -((-s + NBLK - 1) / NBLK);
      m_blk.delete();
    end
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit st, input bit st_rise, input int mg, input int p);
    if (st) begin
      st_in_drive(1'b1);
      bus.rdy_in = 1'b0;
      en = 1'b1;
      tick();
      st_in_drive(1'b0);
      m_arm = 1;
      repeat ($urandom_range(3)) begin
        en = ($urandom_range(3) != 0);
        tick();
      end
    end else begin
      bus.rdy_in = 1'b0;
      en = 1'b1;
      tick();
    end
    en = 1'b1;
    bus.rdy_in = 1'b1;
    st_in_drive(st_rise);
    bus.mag = 16'(mg);
    bus.ph = 18'(p);
    tick();
    st_in_drive(1'b0);
    if (m_arm) model_result(mg, p);
    m_arm = st_rise;
  endtask

  task automatic st_in_drive(input bit v);
    bus.st_in = v;
  endtask

  task automatic do_sclr();
    en = 1'b1;
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    m_arm = 0;
    m_have = 0;
    m_blk.delete();
  endtask

  always @(negedge clk) begin
    if (!reset && en) begin
      if (bus.dph_vld || bus.sq) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sq", int'(bus.sq), int'(e.sq));
          chk("dph_vld", int'(bus.dph_vld), int'(!e.sq));
          if (!e.sq) chk("dph", int'(bus.dph), e.d);
          chk("freq_vld", int'(bus.freq_vld), int'(e.fv));
          if (e.fv) chk("freq", int'(bus.freq), e.f);
        end
      end else if (bus.freq_vld) chk("stray_freq_vld", 1, 0);
    end
  end

  initial begin
    bus.st_in = 1'b0;
    bus.rdy_in = 1'b1;
    bus.mag = '0;
    bus.ph = '0;
    bus.thr = 16'(THR);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_dph", int'(bus.dph), 0);
    chk("rst_dph_vld", int'(bus.dph_vld), 0);
    chk("rst_freq", int'(bus.freq), 0);
    chk("rst_freq_vld", int'(bus.freq_vld), 0);
    chk("rst_sq", int'(bus.sq), 0);
    txn(0, 0, 500, 1234);
    chk("unarmed_rise", int'(bus.dph_vld), 0);
    txn(1, 0, 500, 1000);
    chk("first_no_vld", int'(bus.dph_vld), 0);
    txn(1, 0, 500, 3000);
    chk("step_vld", int'(bus.dph_vld), 1);
    chk("step_dph", int'(bus.dph), 2000);
    chk("step_no_freq", int'(bus.freq_vld), 0);
    txn(1, 0, 500, 60000);
    txn(1, 0, 500, -60000);
    chk("wrap_neg", int'(bus.dph), 11072);
    txn(1, 0, 500, 60000);
    chk("wrap_pos", int'(bus.dph), -11072);
    do_sclr();
    txn(1, 0, 500, 0);
    txn(1, 0, 500, 65536);
    chk("pi_kept", int'(bus.dph), 65536);
    txn(1, 0, 500, 0);
    chk("neg_pi", int'(bus.dph), 65536);
    do_sclr();
    txn(1, 0, 500, 0);
    txn(1, 0, 500, 100);
    txn(1, 0, 500, 300);
    txn(1, 0, 500, 600);
    txn(1, 0, 500, 1001);
    chk("avg_vld", int'(bus.freq_vld), 1);
    chk("avg_freq", int'(bus.freq), 250);
    do_sclr();
    txn(1, 0, 500, 0);
    txn(1, 0, 500, 8);
    txn(1, 0, 500, 16);
    do_sclr();
    for (int i = 0; i <= 4; i++) txn(1, 0, 500, 8 * i);
    chk("avg8_vld", int'(bus.freq_vld), 1);
    chk("avg8_freq", int'(bus.freq), 8);
`ifdef CORDIC_FD_SQUELCH_EN
    do_sclr();
    txn(1, 0, 500, 0);
    txn(1, 0, 50, 900);
    chk("sq_pulse", int'(bus.sq), 1);
    txn(1, 0, 500, 2000);
    chk("sq_reinit", int'(bus.dph_vld), 0);
    txn(1, 0, 500, 2100);
    chk("sq_dph", int'(bus.dph), 100);
`endif
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(40) == 0) do_sclr();
      txn($urandom_range(5) != 0, $urandom_range(7) == 0, int'($urandom_range(1000)), int'($urandom_range(131071)) - 65535);
      repeat ($urandom_range(2)) begin
        en = ($urandom_range(3) != 0);
        tick();
      end
    end
    en = 1'b1;
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/cordic_freq_disc.md
Name: cordic_freq_disc

Overview:
Downstream consumer of the serial CORDIC magnitude/phase stage. It captures each new (mag, ph) result and forms the wrapped phase difference against the previous sample, i.e. a per-sample frequency estimate (FM discriminator). It also produces a block average of that difference over 2^AVG_LOG2 samples. It sits between the CORDIC core and the demodulator/control logic, on the same clk/en domain.

Parameters:
XY_WDT, 16, CORDIC input width; ph/dph/freq width is PH_WDT = XY_WDT+2; pi = 2^XY_WDT (0100..0).
AVG_LOG2, 3, log2 of the averaging block length (1..8).

Ports:
clk  in  1  clock
reset  in  1  async reset, active-high
sclr  in  1  sync clear (qualified by en)
en  in  1  clock enable; no state changes when low
st_in  in  1  copy of start pulse driven to the CORDIC; arms result capture
rdy_in  in  1  CORDIC rdy (level; falls after st, rises when result valid)
mag  in  XY_WDT  CORDIC magnitude, unsigned
ph  in  XY_WDT+2  CORDIC phase, signed, (-pi, pi]
thr  in  XY_WDT  squelch threshold, unsigned
dph  out  XY_WDT+2  wrapped phase difference, signed, (-pi, pi]
dph_vld  out  1  one-cycle pulse, dph valid
freq  out  XY_WDT+2  block average of dph, signed
freq_vld  out  1  one-cycle pulse, freq valid
sq  out  1  one-cycle pulse, sample squelched

Behaviour:
- Reset (async) and sclr (with en): dph, freq, dph_vld, freq_vld, sq = 0. Also clear ph_prev, acc, cnt and armed. Set rdy_d = 1 and state = S_EMPTY.
- All updates occur only when en = 1. Pulses last one enabled cycle.
- armed is set by st_in. A new result is defined as rdy_in & ~rdy_d & armed. A new result clears armed unless st_in is high in the same cycle, in which case armed stays set.
- A rising edge of rdy_in without a prior st_in is ignored. This covers the post-reset ST0 rise.
- State S_EMPTY: on a new result, ph_prev <= ph and the block moves to S_RUN. No dph_vld.
- State S_RUN: on a new result, compute raw = ph - ph_prev in XY_WDT+3 bits.
  - If raw > pi, subtract 2pi. If raw <= -pi, add 2pi.
  - Truncate to PH_WDT bits. Register the result into dph.
  - dph_vld pulses in the cycle after the new result (latency 1). ph_prev <= ph.
- Accumulator acc is PH_WDT+AVG_LOG2 bits, signed; cnt is AVG_LOG2 bits. On each dph produced: acc += dph and cnt++.
  - When cnt == 2^AVG_LOG2-1: freq <= (acc + dph) >>> AVG_LOG2 (arithmetic shift, floor), freq_vld pulses in the same cycle as that dph_vld, then acc <= 0 and cnt <= 0.
- Outputs dph and freq hold their last value between pulses.
- sclr during accumulation discards the partial block. No freq_vld is produced.
- Back-to-back results (every N+2 cycles) are always accepted; there is no backpressure.

Optional Feature:
Macro CORDIC_FD_SQUELCH_EN.
- Defined: a new result with mag < thr is squelched. sq pulses (latency 1), no dph_vld, and state returns to S_EMPTY with acc and cnt cleared. The next unsquelched result only re-initialises ph_prev.
- Undefined: thr is ignored, sq is tied 0, and every result is processed.

Decomposition:
- Package cordic_fd_pkg contains:
  - state enum {S_EMPTY, S_RUN};
  - functions pi_c(XY_WDT) and two_pi_c(XY_WDT) returning the PH_WDT+1-bit constants.
- Sub-module cordic_ph_wrap: combinational module taking ph, ph_prev and returning the wrapped difference. It is reusable by other phase consumers.

Test Plan:
- Reset, then rdy_in 0->1 with no st_in -> no dph_vld; all outputs 0.
- XY_WDT=16: two st/result pairs with ph=1000 then ph=3000 -> dph=2000 with dph_vld 1 cycle after the second rdy rise; no freq_vld.
- Wrap: ph_prev=60000, ph=-60000 -> raw=-120000 -> dph=11072. Then ph_prev=-60000, ph=60000 -> dph=-11072.
- Boundary: ph_prev=0, ph=65536 -> dph=65536 (pi kept). Then ph_prev=65536, ph=0 -> raw=-pi -> dph=65536.
- AVG_LOG2=2: dph sequence 100, 200, 300, 401 -> freq=250 with freq_vld on the fourth dph_vld. sclr after two samples, then four samples of 8 -> freq=8.
- With CORDIC_FD_SQUELCH_EN, thr=100: results mag=500/ph=0, mag=50/ph=900, mag=500/ph=2000, mag=500/ph=2100 -> sq on the second result; only one dph_vld, with dph=100.
